// File: rtl/app_inject_pkg.sv
// rtl/app_inject_pkg.sv - shared types and constants for the application injectors
package app_inject_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int CREDIT_LEVEL = 0;
  localparam int CREDIT_PULSE = 1;

  // Index width that stays legal for a single-channel build
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/app_inject_arbiter_rr_arbiter.sv
// rtl/app_inject_arbiter_rr_arbiter.sv - round-robin arbiter with owned pointer
// Picks the first request at or after the pointer; pointer moves past upd_idx on en.
module rr_arbiter
  import app_inject_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [IDX_W-1:0] upd_idx,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  // Scan from the farthest offset down so the nearest request wins
  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    j         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (int'(upd_idx) == N - 1) ? '0 : upd_idx + 1'b1;
    end
  end

endmodule

// File: rtl/app_inject_arbiter.sv
// rtl/app_inject_arbiter.sv - packet-granular round-robin merge of N_CH streams into one NoC port
module app_inject_arbiter
  import app_inject_pkg::*;
#(
  parameter int FLIT_SIZE   = 32,
  parameter int N_CH        = 2,
  parameter int CREDIT_MODE = 0,
  parameter int MAX_CREDITS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_CH-1:0]           ch_valid_i,
  output logic [N_CH-1:0]           ch_ready_o,
  input  logic [N_CH*FLIT_SIZE-1:0] ch_data_i,
  input  logic [N_CH-1:0]           ch_last_i,
  input  logic [N_CH-1:0]           ch_done_i,
  output logic                      tx_o,
  input  logic                      credit_i,
  output logic [FLIT_SIZE-1:0]      data_o,
  output logic                      eoa_o,
  output logic [CNT_W-1:0]          pkt_cnt_o,
  output logic                      credit_err_o
);

  localparam int IDX_W = idx_width(N_CH);
  localparam int CRD_W = $clog2(MAX_CREDITS + 1);

  typedef struct packed {
    logic [FLIT_SIZE-1:0] data;
    logic                 last;
  } oreg_t;

  state_t           state;
  logic [IDX_W-1:0] grant_q, arb_idx, sel_idx;
  logic [N_CH-1:0]  arb_grant, sel_oh;
  oreg_t            oreg;
  logic             oreg_full;
  logic [CRD_W-1:0] cred;
  logic [CNT_W-1:0] pkt_cnt;
  logic             eoa, credit_err;
  logic             can_send, send, loadable, accept, sel_valid, sel_last;
  logic [FLIT_SIZE-1:0] sel_data;

  rr_arbiter #(.N(N_CH), .IDX_W(IDX_W)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req       (ch_valid_i),
    .en        (accept & sel_last),
    .upd_idx   (sel_idx),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign can_send = (CREDIT_MODE == CREDIT_LEVEL) ? credit_i : (cred != '0);
  assign send     = oreg_full & can_send;
  assign loadable = ~oreg_full | send;

  // In IDLE the arbiter decision is used in the same cycle; in XFER the held grant
  always_comb begin
    sel_idx = (state == IDLE) ? arb_idx : grant_q;
    sel_oh  = '0;
    if (state == IDLE) sel_oh = arb_grant;
    else               sel_oh[grant_q] = 1'b1;
    sel_data = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel_oh[c]) sel_data = ch_data_i[c*FLIT_SIZE +: FLIT_SIZE];
    end
  end

  assign sel_valid  = |(ch_valid_i & sel_oh);
  assign sel_last   = |(ch_last_i & sel_oh);
  assign accept     = loadable & sel_valid;
  assign ch_ready_o = (rst_i || !loadable) ? '0 : sel_oh;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      grant_q <= '0;
    end else begin
      case (state)
        IDLE: if (|ch_valid_i) begin
          grant_q <= arb_idx;
          state   <= (accept && sel_last) ? IDLE : XFER;
        end
        XFER: if (accept && sel_last) state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      oreg      <= '0;
      oreg_full <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      if (accept) begin
        oreg      <= '{data: sel_data, last: sel_last};
        oreg_full <= 1'b1;
      end else if (send) begin
        oreg_full <= 1'b0;
      end
      if (send && oreg.last) pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

  // Counted credits: a return and a send in the same cycle cancel out
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cred       <= CRD_W'(MAX_CREDITS);
      credit_err <= 1'b0;
    end else if (CREDIT_MODE == CREDIT_PULSE) begin
      if (send && !credit_i) begin
        cred <= cred - 1'b1;
      end else if (!send && credit_i) begin
        if (cred == CRD_W'(MAX_CREDITS)) credit_err <= 1'b1;
        else                             cred <= cred + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      eoa <= 1'b0;
    end else if ((&ch_done_i) && state == IDLE && !oreg_full && !(|ch_valid_i)) begin
      eoa <= 1'b1;
    end
  end

  assign tx_o         = oreg_full;
  assign data_o       = oreg.data;
  assign pkt_cnt_o    = pkt_cnt;
  assign eoa_o        = eoa;
  assign credit_err_o = credit_err;

endmodule
